trace_line_arbiter: RTL and testbench
=====================================

# trace_line_arbiter

Shares one `cpu_checker` between two independent trace-character sources. Grants whole lines (from `^` through `#`) to one requester at a time with round-robin fairness, drives the checker's `char` input and inserts 8'h00 filler when no line is active. Captures the checker's `format_type` and returns it as a tagged result, or reports an aborted line. Sits between the trace sources and the checker instance.

## Interface

- `MAX_LEN`, 64: maximum characters per line, including `^` and `#` (used only when `LINE_TIMEOUT_EN` is defined).
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `req0_valid`  input  1  requester 0 presents a character.
- `req0_char`  input  8  requester 0 ASCII character.
- `req0_ready`  output  1  requester 0 character accepted this cycle (combinational).
- `req1_valid`, `req1_char`, `req1_ready`: same as above, for requester 1.
- `chk_char`  output  8  registered character driven to `cpu_checker.char`.
- `chk_format`  input  2  `cpu_checker.format_type`.
- `res_valid`  output  1  one-cycle result pulse (registered).
- `res_src`  output  1  requester the result belongs to.
- `res_type`  output  2  captured `chk_format`; forced to 0 on abort.
- `res_abort`  output  1  line was aborted (source stall or timeout).

## Operation

- States: IDLE, BUSY, WAIT1, WAIT2. Registers: `state`, `src`, `last_grant`, `len`.
- A transfer happens on a clock edge when `reqN_valid` and `reqN_ready` are both high. The accepted character appears on `chk_char` after that edge.
- IDLE:
  - A requester with `valid` high and `char=="^"` is a candidate.
  - With one candidate, that requester wins. With two candidates, the requester other than `last_grant` wins.
  - The winner gets `ready=1`. Its `^` is accepted, `src` and `last_grant` are set to the winner, `len` is set to 1, and the state moves to BUSY.
  - A losing candidate gets `ready=0`.
  - A requester presenting a non-`^` character gets `ready=1`. The character is discarded and `chk_char` stays 8'h00.
- BUSY:
  - Only `src` may get `ready`; the other requester's `ready` is 0.
  - If `valid` is high, the character is accepted and `len` increments. If the character is `#`, the state moves to WAIT1.
  - If `valid` is low, the line is aborted: `chk_char` is set to 8'h00, an abort result is issued and the state returns to IDLE. The source must not stall mid-line.
- WAIT1: `chk_char`=8'h00. The checker consumes `#` on this edge. Move to WAIT2.
- WAIT2: `chk_char`=8'h00. Sample `chk_format`. On the next edge set `res_valid`=1, `res_src`=`src`, `res_type`=`chk_format`, `res_abort`=0, and move to IDLE.
- Abort result: `res_valid`=1, `res_abort`=1, `res_type`=0, `res_src`=`src`, asserted on the edge following the abort decision.
- `res_valid` is high for exactly one cycle per granted line, whether the line completes or aborts.
- `len` width is $clog2(MAX_LEN+1) and saturates; it never wraps.

## Timing

- Reset (asynchronous, active-low): state=IDLE, `last_grant`=1 (requester 0 wins the first tie), `chk_char`=8'h00, `res_valid`=0, `res_src`=0, `res_type`=0, `res_abort`=0, `len`=0. Outputs clear immediately when reset asserts, including mid-line. No result is issued for a line interrupted by reset.
- Character latency: edge of acceptance to `chk_char` is 1 cycle.
- Result latency: `res_valid` rises on the 3rd edge after the edge that accepts `#` (WAIT1, WAIT2, then result).
- Abort latency: `res_valid` rises on the 1st edge after the abort decision.
- Back-to-back lines: IDLE can grant a new `^` on the cycle after WAIT2, so there are at least 3 filler cycles between lines on `chk_char`.
- Simultaneous `^` from both requesters: strict alternation. A requester that loses keeps `valid` and `char` stable until it is granted.

## Configuration

- `LINE_TIMEOUT_EN` defined:
  - In BUSY, when `len==MAX_LEN` and the line has no `#` yet, `ready`=0 for that cycle and the line is aborted as above.
  - `#` must therefore be among the first `MAX_LEN` characters.
- Not defined: `len` and `MAX_LEN` are unused and removed. A line ends only on `#` or a source stall.

## Test plan

- Register line: req0 sends `^10@00003000: $2 <= 89abcd3f#` continuously. Required: `chk_char` equals the stream delayed 1 cycle; `res_valid` 3 edges after `#` with `res_src`=0, `res_type`=2'b01, `res_abort`=0.
- Memory line: req1 sends `^1024@00003000: *00000088 <= 89abcdef#`. Required: `res_src`=1, `res_type`=2'b10.
- Arbitration: right after reset, both requesters present `^` on the same cycle.
  - Required: req0 granted and `req1_ready`=0 until req0's line completes; then req1 granted.
  - On the next tie, req0 wins.
- Stall: req0 drops `valid` after `^10@`. Required: `chk_char`=8'h00 next cycle; result `res_abort`=1, `res_src`=0, `res_type`=0.
- Timeout: with `LINE_TIMEOUT_EN` and `MAX_LEN`=8, req0 sends 8 non-`#` characters starting with `^`. Required: the 9th character is not accepted (`ready`=0) and an abort result with `res_src`=0 follows.
- IDLE garbage and reset:
  - req1 sends `ab` in IDLE. Required: `req1_ready`=1, `chk_char` stays 8'h00, no result.
  - Assert `reset` low mid-BUSY. Required: all outputs 0 within the same cycle, no result afterwards.

Source files
------------

// File: rtl/trace_line_arbiter_if.sv
// Handshake bundle between two trace sources, the line arbiter and cpu_checker.
// master: trace sources plus checker side (drive requests and format_type).
// slave: the arbiter (drives ready, checker char and the tagged result).
interface trace_line_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_char;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_char;
    logic       req1_ready;
    logic [7:0] chk_char;
    logic [1:0] chk_format;
    logic       res_valid;
    logic       res_src;
    logic [1:0] res_type;
    logic       res_abort;

    modport master (
        output req0_valid, req0_char, req1_valid, req1_char, chk_format,
        input  req0_ready, req1_ready, chk_char, res_valid, res_src, res_type, res_abort
    );

    modport slave (
        input  req0_valid, req0_char, req1_valid, req1_char, chk_format,
        output req0_ready, req1_ready, chk_char, res_valid, res_src, res_type, res_abort
    );
endinterface

// File: rtl/trace_line_arbiter.sv
// Grants whole '^'..'#' trace lines from two sources round-robin to one cpu_checker; filler 8'h00 otherwise.
// Latency: char 1 cycle to chk_char; result 3 edges after '#' accepted, abort result 1 edge after the stall.
// Backpressure: combinational ready; losing/idle-waiting source held off; LINE_TIMEOUT_EN adds a MAX_LEN cut-off.
module trace_line_arbiter #(
    parameter int MAX_LEN = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    trace_line_arbiter_if.slave  bus
);
    localparam logic [7:0] CH_START = 8'h5E;  // '^'
    localparam logic [7:0] CH_END   = 8'h23;  // '#'

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        WAIT1 = 2'd2,
        WAIT2 = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_src, w_src_nxt;
    logic       r_last_grant, w_last_grant_nxt;
    // WAIT2 spans two cycles: first edge captures format_type, second issues the result.
    logic       r_fmt_held, w_fmt_held_nxt;
    logic [1:0] r_fmt, w_fmt_nxt;
    logic [7:0] r_chk_char, w_chk_char_nxt;
    logic       r_res_valid, w_res_valid_nxt;
    logic       r_res_src, w_res_src_nxt;
    logic [1:0] r_res_type, w_res_type_nxt;
    logic       r_res_abort, w_res_abort_nxt;
    logic       w_rdy0, w_rdy1;

    logic       w_cand0, w_cand1, w_win0, w_win1;
    logic       w_src_valid;
    logic [7:0] w_src_char;
    logic       w_timeout;

`ifdef LINE_TIMEOUT_EN
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    logic [LEN_W-1:0] r_len, w_len_nxt;
    assign w_timeout = (r_len == LEN_W'(MAX_LEN));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_cand0 = bus.req0_valid && (bus.req0_char == CH_START);
    assign w_cand1 = bus.req1_valid && (bus.req1_char == CH_START);
    // On a tie the requester that was not granted last time wins.
    assign w_win0  = w_cand0 && (!w_cand1 || r_last_grant);
    assign w_win1  = w_cand1 && (!w_cand0 || !r_last_grant);

    assign w_src_valid = r_src ? bus.req1_valid : bus.req0_valid;
    assign w_src_char  = r_src ? bus.req1_char  : bus.req0_char;

    // Next-state, handshake and registered-output decode for the line FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_src_nxt        = r_src;
        w_last_grant_nxt = r_last_grant;
        w_fmt_held_nxt   = 1'b0;
        w_fmt_nxt        = r_fmt;
        w_chk_char_nxt   = 8'h00;
        w_res_valid_nxt  = 1'b0;
        w_res_src_nxt    = r_res_src;
        w_res_type_nxt   = r_res_type;
        w_res_abort_nxt  = r_res_abort;
        w_rdy0           = 1'b0;
        w_rdy1           = 1'b0;
`ifdef LINE_TIMEOUT_EN
        w_len_nxt        = r_len;
`endif
        case (r_state)
            IDLE: begin
                // Non-'^' characters are swallowed so a source can resync onto a line start.
                w_rdy0 = !w_cand0 || w_win0;
                w_rdy1 = !w_cand1 || w_win1;
                if (w_win0 || w_win1) begin
                    w_src_nxt        = w_win1;
                    w_last_grant_nxt = w_win1;
                    w_chk_char_nxt   = CH_START;
                    w_state_nxt      = BUSY;
`ifdef LINE_TIMEOUT_EN
                    w_len_nxt        = LEN_W'(1);
`endif
                end
            end
            BUSY: begin
                if (w_timeout || !w_src_valid) begin
                    // A stalled or over-long line can no longer be checked; report it and free the checker.
                    w_res_valid_nxt = 1'b1;
                    w_res_abort_nxt = 1'b1;
                    w_res_type_nxt  = 2'b00;
                    w_res_src_nxt   = r_src;
                    w_state_nxt     = IDLE;
                end else begin
                    w_rdy0         = !r_src;
                    w_rdy1         = r_src;
                    w_chk_char_nxt = w_src_char;
`ifdef LINE_TIMEOUT_EN
                    if (r_len != {LEN_W{1'b1}}) begin
                        w_len_nxt = r_len + LEN_W'(1);
                    end
`endif
                    if (w_src_char == CH_END) begin
                        w_state_nxt = WAIT1;
                    end
                end
            end
            WAIT1: begin
                w_state_nxt = WAIT2;
            end
            WAIT2: begin
                if (!r_fmt_held) begin
                    w_fmt_held_nxt = 1'b1;
                    w_fmt_nxt      = bus.chk_format;
                end else begin
                    w_res_valid_nxt = 1'b1;
                    w_res_abort_nxt = 1'b0;
                    w_res_type_nxt  = r_fmt;
                    w_res_src_nxt   = r_src;
                    w_state_nxt     = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any line in flight without a result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_src        <= 1'b0;
            r_last_grant <= 1'b1;
            r_fmt_held   <= 1'b0;
            r_fmt        <= 2'b00;
            r_chk_char   <= 8'h00;
            r_res_valid  <= 1'b0;
            r_res_src    <= 1'b0;
            r_res_type   <= 2'b00;
            r_res_abort  <= 1'b0;
`ifdef LINE_TIMEOUT_EN
            r_len        <= '0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_src        <= w_src_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_fmt_held   <= w_fmt_held_nxt;
            r_fmt        <= w_fmt_nxt;
            r_chk_char   <= w_chk_char_nxt;
            r_res_valid  <= w_res_valid_nxt;
            r_res_src    <= w_res_src_nxt;
            r_res_type   <= w_res_type_nxt;
            r_res_abort  <= w_res_abort_nxt;
`ifdef LINE_TIMEOUT_EN
            r_len        <= w_len_nxt;
`endif
        end
    end

    // Ready is masked by reset so no handshake can appear while the block is held.
    assign bus.req0_ready = w_rdy0 & reset;
    assign bus.req1_ready = w_rdy1 & reset;
    assign bus.chk_char   = r_chk_char;
    assign bus.res_valid  = r_res_valid;
    assign bus.res_src    = r_res_src;
    assign bus.res_type   = r_res_type;
    assign bus.res_abort  = r_res_abort;
endmodule

// File: tb/tb_trace_line_arbiter.sv
// Randomized and directed bench for trace_line_arbiter against a line-level timing model.
// Model: lines owned whole, '#' result 4 cycles later, abort result next cycle, tie alternation.
// Sources are queue-driven agents that hold their head character until ready.
module tb_trace_line_arbiter;
`ifdef LINE_TIMEOUT_EN
    localparam int TB_MAX_LEN = 8;
`else
    localparam int TB_MAX_LEN = 64;
`endif
    localparam int MAXC = 8192;

    logic clk;
    logic reset;
    trace_line_arbiter_if bus();

    trace_line_arbiter #(.MAX_LEN(TB_MAX_LEN)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Expected registered outputs, indexed by the cycle in which they are visible.
    logic [7:0] e_chk  [MAXC];
    bit         e_rv   [MAXC];
    bit         e_src  [MAXC];
    logic [1:0] e_type [MAXC];
    bit         e_ab   [MAXC];

    // Per-source character queues (8'h00 = one cycle with valid low) and line types.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [1:0] t0[$];
    logic [1:0] t1[$];

    bit         m_active;
    int         m_owner;
    int         m_free_at;
    bit         m_last;
    int         m_len;
    logic [1:0] m_type;
    int         f_from;
    int         f_to;
    logic [1:0] f_val;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] b);
        if (r == 0) q0.push_back(b); else q1.push_back(b);
    endtask

    task automatic push_type(input int r, input logic [1:0] t);
        if (r == 0) t0.push_back(t); else t1.push_back(t);
    endtask

    task automatic push_str(input int r, input string s);
        for (int i = 0; i < s.len(); i++) push_byte(r, s[i]);
    endtask

    task automatic rand_line(input int r, input int minb, input int maxb);
        int n;
        logic [7:0] c;
        n = $urandom_range(maxb, minb);
        push_byte(r, 8'h5E);
        for (int i = 0; i < n; i++) begin
            c = 8'($urandom_range(8'h7E, 8'h20));
            if (c == 8'h5E || c == 8'h23) c = 8'h78;
            push_byte(r, c);
        end
        push_byte(r, 8'h23);
        push_type(r, 2'($urandom_range(3, 0)));
    endtask

    task automatic garbage(input int r, input int n);
        for (int i = 0; i < n; i++) push_byte(r, 8'($urandom_range(8'h7A, 8'h61)));
    endtask

    task automatic clear_expect(input int from, input int to);
        for (int i = from; i <= to; i++) begin
            if (i >= 0 && i < MAXC) begin
                e_chk[i] = 8'h00; e_rv[i] = 1'b0; e_src[i] = 1'b0; e_type[i] = 2'b00; e_ab[i] = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_active  = 1'b0;
        m_owner   = 0;
        m_free_at = cyc;
        m_last    = 1'b1;
        m_len     = 0;
        m_type    = 2'b00;
        f_from    = -1;
        f_to      = -2;
        f_val     = 2'b00;
    endtask

    // One clock cycle: drive queue heads, predict, compare, consume on handshake.
    task automatic step();
        logic [7:0] h0, h1, oc;
        logic v0, v1, ov;
        bit er0, er1, cand0, cand1, tmo;
        int win;
        if (cyc + 5 >= MAXC) begin
            $display("FAIL cycle_budget: exceeded %0d cycles", MAXC);
            $fatal(1);
        end
        @(negedge clk);
        h0 = (q0.size() > 0) ? q0[0] : 8'h00;
        h1 = (q1.size() > 0) ? q1[0] : 8'h00;
        v0 = (h0 != 8'h00);
        v1 = (h1 != 8'h00);
        bus.req0_valid = v0;
        bus.req1_valid = v1;
        bus.req0_char  = v0 ? h0 : 8'($urandom);
        bus.req1_char  = v1 ? h1 : 8'($urandom);
        bus.chk_format = (cyc >= f_from && cyc <= f_to) ? f_val : 2'($urandom);
        #1;
        er0 = 1'b0;
        er1 = 1'b0;
        if (!m_active && cyc >= m_free_at) begin
            cand0 = v0 && (h0 == 8'h5E);
            cand1 = v1 && (h1 == 8'h5E);
            win = -1;
            if (cand0 && cand1) win = m_last ? 0 : 1;
            else if (cand0)     win = 0;
            else if (cand1)     win = 1;
            er0 = !cand0 || (win == 0);
            er1 = !cand1 || (win == 1);
            if (win >= 0) begin
                m_active  = 1'b1;
                m_owner   = win;
                m_last    = (win == 1);
                m_len     = 1;
                m_free_at = MAXC;
                e_chk[cyc+1] = 8'h5E;
                if (win == 0) m_type = (t0.size() > 0) ? t0.pop_front() : 2'b00;
                else          m_type = (t1.size() > 0) ? t1.pop_front() : 2'b00;
            end
        end else if (m_active) begin
            ov = (m_owner == 1) ? v1 : v0;
            oc = (m_owner == 1) ? h1 : h0;
`ifdef LINE_TIMEOUT_EN
            tmo = (m_len == TB_MAX_LEN);
`else
            tmo = 1'b0;
`endif
            if (m_owner == 0) er0 = !tmo; else er1 = !tmo;
            if (tmo || !ov) begin
                m_active  = 1'b0;
                m_free_at = cyc + 1;
                e_rv[cyc+1] = 1'b1; e_src[cyc+1] = (m_owner == 1); e_type[cyc+1] = 2'b00; e_ab[cyc+1] = 1'b1;
            end else begin
                e_chk[cyc+1] = oc;
                m_len++;
                if (oc == 8'h23) begin
                    m_active  = 1'b0;
                    m_free_at = cyc + 4;
                    e_rv[cyc+4] = 1'b1; e_src[cyc+4] = (m_owner == 1); e_type[cyc+4] = m_type; e_ab[cyc+4] = 1'b0;
                    f_from = cyc + 1; f_to = cyc + 3; f_val = m_type;
                end
            end
        end
        if (v0) chk("req0_ready", {7'd0, bus.req0_ready}, {7'd0, er0});
        if (v1) chk("req1_ready", {7'd0, bus.req1_ready}, {7'd0, er1});
        chk("chk_char", bus.chk_char, e_chk[cyc]);
        chk("res_valid", {7'd0, bus.res_valid}, {7'd0, e_rv[cyc]});
        if (e_rv[cyc]) begin
            chk("res_src",   {7'd0, bus.res_src},   {7'd0, e_src[cyc]});
            chk("res_type",  {6'd0, bus.res_type},  {6'd0, e_type[cyc]});
            chk("res_abort", {7'd0, bus.res_abort}, {7'd0, e_ab[cyc]});
        end
        if (q0.size() > 0 && (!v0 || bus.req0_ready)) void'(q0.pop_front());
        if (q1.size() > 0 && (!v1 || bus.req1_ready)) void'(q1.pop_front());
        cyc++;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || m_active || cyc < m_free_at) && n < 1500) begin
            step();
            n++;
        end
        checks++;
        assert (n < 1500) else begin
            fails++;
            $error("FAIL drain_%s cycles=%0d limit=1500", tag, n);
        end
        repeat (2) step();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_chk_char"},   bus.chk_char, 8'h00);
        chk({tag, "_res_valid"},  {7'd0, bus.res_valid},  8'h00);
        chk({tag, "_res_src"},    {7'd0, bus.res_src},    8'h00);
        chk({tag, "_res_type"},   {6'd0, bus.res_type},   8'h00);
        chk({tag, "_res_abort"},  {7'd0, bus.res_abort},  8'h00);
        chk({tag, "_req0_ready"}, {7'd0, bus.req0_ready}, 8'h00);
        chk({tag, "_req1_ready"}, {7'd0, bus.req1_ready}, 8'h00);
    endtask

    initial begin
        int kind, r, n;
        for (int i = 0; i < MAXC; i++) begin
            e_chk[i] = 8'h00; e_rv[i] = 1'b0; e_src[i] = 1'b0; e_type[i] = 2'b00; e_ab[i] = 1'b0;
        end
        reset = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_char = 8'h00;
        bus.req1_valid = 1'b0; bus.req1_char = 8'h00;
        bus.chk_format = 2'b00;
        model_reset();
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Tie straight after reset: req0 first, then req1; next tie goes to req0 again.
        push_str(0, "^10@00003000: $2 <= 89abcd3f#");             push_type(0, 2'b01);
        push_str(1, "^1024@00003000: *00000088 <= 89abcdef#");    push_type(1, 2'b10);
        drain("first_tie");
        push_str(0, "^10@00003000: $2 <= 89abcd3f#");             push_type(0, 2'b01);
        push_str(1, "^1024@00003000: *00000088 <= 89abcdef#");    push_type(1, 2'b10);
        drain("second_tie");

        // Register line alone, then memory line alone.
        push_str(0, "^10@00003000: $2 <= 89abcd3f#");             push_type(0, 2'b01);
        drain("register_line");
        push_str(1, "^1024@00003000: *00000088 <= 89abcdef#");    push_type(1, 2'b10);
        drain("memory_line");

        // Source stall mid-line aborts it.
        push_str(0, "^10@"); push_type(0, 2'b01); push_byte(0, 8'h00);
        drain("stall");

        // Garbage outside a line is consumed and produces nothing.
        push_str(1, "ab");
        drain("idle_garbage");

`ifdef LINE_TIMEOUT_EN
        // Eight characters without '#' hit the length limit.
        push_str(0, "^abcdefgh#"); push_type(0, 2'b11);
        drain("timeout");
`endif

        // Random mix of lines, ties, stalls, staggered arrivals and garbage.
        for (int ep = 0; ep < 40; ep++) begin
            kind = $urandom_range(3, 0);
            r    = $urandom_range(1, 0);
            case (kind)
                0: begin
                    garbage(r, $urandom_range(2, 0));
                    for (int g = 0; g < int'($urandom_range(2, 0)); g++) push_byte(r, 8'h00);
                    rand_line(r, 1, 20);
                end
                1: begin
                    rand_line(0, 1, 12);
                    rand_line(1, 1, 12);
                    if ($urandom_range(1, 0) == 1) rand_line(r, 1, 6);
                end
                2: begin
                    push_byte(r, 8'h5E);
                    n = $urandom_range(5, 0);
                    for (int k = 0; k < n; k++) push_byte(r, 8'($urandom_range(8'h39, 8'h30)));
                    push_type(r, 2'b01);
                    push_byte(r, 8'h00);
                end
                default: begin
                    rand_line(r, 4, 16);
                    for (int g = 0; g < int'($urandom_range(8, 1)); g++) push_byte(1 - r, 8'h00);
                    rand_line(1 - r, 1, 10);
                end
            endcase
            drain("random");
        end

        // Reset in the middle of a granted line.
        rand_line(0, 12, 16);
        n = 0;
        while (!(m_active && m_len >= 3) && n < 100) begin
            step();
            n++;
        end
        checks++;
        assert (n < 100) else begin
            fails++;
            $error("FAIL reset_setup_grant cycles=%0d limit=100", n);
        end
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        q0.delete(); q1.delete(); t0.delete(); t1.delete();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_expect(cyc - 1, cyc + 8);
        model_reset();
        repeat (8) step();

        // Arbitration pointer is back to its reset value: req0 wins the tie.
        push_str(0, "^10@00003000: $2 <= 89abcd3f#");             push_type(0, 2'b01);
        push_str(1, "^1024@00003000: *00000088 <= 89abcdef#");    push_type(1, 2'b10);
        drain("tie_after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
